// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: latch enables, bubbles, MEM-wait timeout,
// post-halt drain and stall-cycle counting.
module pipeline_controller #(
  parameter int unsigned DWAIT_MAX = 255,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_load,
  input  logic [4:0]       ex_dest,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_uses_rt,
  input  logic             dec_redirect,
  input  logic             dec_halt,
  output logic             if_en,
  output logic             dec_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             dec_flush,
  output logic             ex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(DWAIT_MAX);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [1:0] drain_cnt;

  logic dreq;
  logic dstall;
  logic lu_haz;
  logic timeout;

  assign dreq    = mem_dREN | mem_dWEN;
  assign dstall  = dreq & ~dhit;
  assign lu_haz  = ex_load && (ex_dest != '0) &&
                   ((ex_dest == dec_rs) || (dec_uses_rt && (ex_dest == dec_rt)));
  assign timeout = dstall && (wait_cnt == WAIT_LIMIT);

  always_comb begin
    if_en     = 1'b1;
    dec_en    = 1'b1;
    ex_en     = 1'b1;
    mem_en    = 1'b1;
    dec_flush = 1'b0;
    ex_flush  = 1'b0;
    if (state == HALTED || dstall) begin
      if_en  = 1'b0;
      dec_en = 1'b0;
      ex_en  = 1'b0;
      mem_en = 1'b0;
    end else if (state == RUN) begin
      if (lu_haz) begin
        if_en    = 1'b0;
        dec_en   = 1'b0;
        ex_flush = 1'b1;
      end else if (dec_redirect && !ihit) begin
        // Hold the branch in DEC so its PC redirect survives the fetch miss.
        if_en    = 1'b0;
        dec_en   = 1'b0;
        ex_flush = 1'b1;
      end else if (!ihit) begin
        if_en     = 1'b0;
        dec_flush = 1'b1;
      end else if (dec_redirect) begin
        dec_flush = 1'b1;
      end
    end
    // While draining, fetch is shut off and IF/DEC only ever receives NOPs.
    if (state == DRAIN) begin
      if_en     = 1'b0;
      dec_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      stall_cnt <= '0;
      halted    <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      if (!if_en && state != HALTED && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (state != HALTED && !timeout)
        wait_cnt <= dstall ? wait_cnt + 8'd1 : '0;

      unique case (state)
        RUN: begin
          if (timeout) begin
            mem_err <= 1'b1;
            state   <= HALTED;
          end else if (dec_halt && dec_en && !dstall) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          if (timeout) begin
            mem_err <= 1'b1;
            state   <= HALTED;
          end else if (mem_en) begin
            drain_cnt <= drain_cnt - 2'd1;
            if (drain_cnt == 2'd1) begin
              halted <= 1'b1;
              state  <= HALTED;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: load-use, MEM wait/timeout, branch miss, priority, drain, reset.
module tb_pipeline_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, mem_dREN, mem_dWEN, ex_load, dec_uses_rt, dec_redirect, dec_halt;
  logic [4:0]  ex_dest, dec_rs, dec_rt;
  logic        if_en, dec_en, ex_en, mem_en, dec_flush, ex_flush, halted, mem_err;
  logic [31:0] stall_cnt;
  logic [5:0]  ctrl;

  int checks   = 0;
  int failures = 0;

  pipeline_controller #(.DWAIT_MAX(255), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .ex_load(ex_load), .ex_dest(ex_dest), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rt(dec_uses_rt), .dec_redirect(dec_redirect), .dec_halt(dec_halt),
    .if_en(if_en), .dec_en(dec_en), .ex_en(ex_en), .mem_en(mem_en),
    .dec_flush(dec_flush), .ex_flush(ex_flush), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  // {if_en, dec_en, ex_en, mem_en, dec_flush, ex_flush}
  assign ctrl = {if_en, dec_en, ex_en, mem_en, dec_flush, ex_flush};

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    ex_load = 1'b0; ex_dest = '0; dec_rs = '0; dec_rt = '0;
    dec_uses_rt = 1'b0; dec_redirect = 1'b0; dec_halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 6'b111100); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_load = 1'b1; ex_dest = 5'd2; dec_rs = 5'd2; dec_rt = 5'd4; dec_uses_rt = 1'b1;
    #1;
    checks++; if (ctrl !== 6'b001101) begin failures++; $display("FAIL lu_bubble got=%b exp=%b", ctrl, 6'b001101); end
    step();
    ex_load = 1'b0; ex_dest = '0;
    #1;
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL lu_release got=%b exp=%b", ctrl, 6'b111100); end
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    ex_load = 1'b1; ex_dest = 5'd7; dec_rs = 5'd1; dec_rt = 5'd7; dec_uses_rt = 1'b1;
    #1;
    checks++; if (ctrl !== 6'b001101) begin failures++; $display("FAIL lu_rt_match got=%b exp=%b", ctrl, 6'b001101); end
    dec_uses_rt = 1'b0;
    #1;
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL lu_rt_unused got=%b exp=%b", ctrl, 6'b111100); end
    ex_dest = 5'd0; dec_rs = 5'd0; dec_rt = 5'd0; dec_uses_rt = 1'b1;
    #1;
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL lu_dest_zero got=%b exp=%b", ctrl, 6'b111100); end
  endtask

  task automatic test_data_wait();
    do_reset();
    mem_dWEN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctrl !== 6'b000000) begin failures++; $display("FAIL dwait_freeze cyc=%0d got=%b exp=%b", i, ctrl, 6'b000000); end
      step();
    end
    dhit = 1'b1;
    #1;
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL dwait_release got=%b exp=%b", ctrl, 6'b111100); end
    checks++; if (stall_cnt !== 32'd4) begin failures++; $display("FAIL dwait_stall_cnt got=%0d exp=4", stall_cnt); end
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 255; i++) step();
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", mem_err); end
    step();
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL tmo_mem_err got=%b exp=1", mem_err); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL tmo_halted got=%b exp=0", halted); end
    mem_dREN = 1'b0; dhit = 1'b1;
    step(); step();
    checks++; if (ctrl !== 6'b000000) begin failures++; $display("FAIL tmo_frozen got=%b exp=%b", ctrl, 6'b000000); end
    checks++; if (stall_cnt !== 32'd256) begin failures++; $display("FAIL tmo_stall_cnt got=%0d exp=256", stall_cnt); end
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", mem_err); end
  endtask

  task automatic test_branch_miss();
    do_reset();
    dec_redirect = 1'b1; ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctrl !== 6'b001101) begin failures++; $display("FAIL br_hold cyc=%0d got=%b exp=%b", i, ctrl, 6'b001101); end
      step();
    end
    ihit = 1'b1;
    #1;
    checks++; if (ctrl !== 6'b111110) begin failures++; $display("FAIL br_squash got=%b exp=%b", ctrl, 6'b111110); end
    checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL br_stall_cnt got=%0d exp=2", stall_cnt); end
    step();
    dec_redirect = 1'b0; ihit = 1'b0;
    #1;
    checks++; if (ctrl !== 6'b011110) begin failures++; $display("FAIL imiss got=%b exp=%b", ctrl, 6'b011110); end
    ihit = 1'b1;
  endtask

  task automatic test_priority();
    do_reset();
    ex_load = 1'b1; ex_dest = 5'd3; dec_rs = 5'd3; mem_dWEN = 1'b1; dhit = 1'b0;
    #1;
    checks++; if (ctrl !== 6'b000000) begin failures++; $display("FAIL prio_freeze got=%b exp=%b", ctrl, 6'b000000); end
    step();
    dhit = 1'b1;
    #1;
    checks++; if (ctrl !== 6'b001101) begin failures++; $display("FAIL prio_bubble got=%b exp=%b", ctrl, 6'b001101); end
    step();
    ex_load = 1'b0; ex_dest = '0; mem_dWEN = 1'b0;
    #1;
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL prio_release got=%b exp=%b", ctrl, 6'b111100); end
    checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL prio_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_halt_drain();
    logic [5:0] exp_ctrl [5];
    exp_ctrl[0] = 6'b011110; exp_ctrl[1] = 6'b000010; exp_ctrl[2] = 6'b000010;
    exp_ctrl[3] = 6'b011110; exp_ctrl[4] = 6'b011110;
    do_reset();
    dec_halt = 1'b1;
    #1;
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL drain_entry got=%b exp=%b", ctrl, 6'b111100); end
    step();
    dec_halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_dWEN = (i == 1 || i == 2);
      dhit     = !(i == 1 || i == 2);
      #1;
      checks++; if (ctrl !== exp_ctrl[i]) begin failures++; $display("FAIL drain_ctrl cyc=%0d got=%b exp=%b", i, ctrl, exp_ctrl[i]); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL drain_early_halt cyc=%0d got=%b exp=0", i, halted); end
      step();
    end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL drain_halted got=%b exp=1", halted); end
    checks++; if (ctrl !== 6'b000000) begin failures++; $display("FAIL drain_final got=%b exp=%b", ctrl, 6'b000000); end
    step(); step();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL drain_sticky got=%b exp=1", halted); end
    checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL drain_stall_cnt got=%0d exp=5", stall_cnt); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL drain_mem_err got=%b exp=0", mem_err); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    dec_halt = 1'b1;
    step();
    dec_halt = 1'b0;
    step();
    checks++; if (ctrl !== 6'b011110) begin failures++; $display("FAIL rmd_in_drain got=%b exp=%b", ctrl, 6'b011110); end
    checks++; if (stall_cnt !== 32'd1) begin failures++; $display("FAIL rmd_pre_cnt got=%0d exp=1", stall_cnt); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL rmd_ctrl got=%b exp=%b", ctrl, 6'b111100); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rmd_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rmd_halted got=%b exp=0", halted); end
    #1;
    RST = 1'b0;
    step(); step(); step(); step();
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rmd_no_pending got=%b exp=0", halted); end
    checks++; if (ctrl !== 6'b111100) begin failures++; $display("FAIL rmd_run got=%b exp=%b", ctrl, 6'b111100); end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_data_wait();
    test_timeout();
    test_reset();
    test_branch_miss();
    test_priority();
    test_halt_drain();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, DEC, EX, MEM, WB) that the forwarding unit serves. It produces per-stage latch enables and bubble/flush controls from cache handshakes, load-use hazards, decode-stage branch/jump redirects and halt. It also tracks data-memory wait timeouts, runs the post-halt drain, and counts stall cycles. Forwarding resolves all other RAW hazards; this block only covers the cases forwarding cannot.

Parameters:
DWAIT_MAX, 255, max consecutive MEM-stage wait cycles before timeout error
CNT_W, 32, stall counter width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
ihit  input  1  instruction fetch complete this cycle
dhit  input  1  data access complete this cycle
mem_dREN  input  1  MEM-stage instruction is a load
mem_dWEN  input  1  MEM-stage instruction is a store
ex_load  input  1  EX-stage instruction is LW
ex_dest  input  5  EX-stage destination register
dec_rs  input  5  DEC-stage rs field
dec_rt  input  5  DEC-stage rt field
dec_uses_rt  input  1  DEC instruction reads rt (R-type, BEQ/BNE, SW)
dec_redirect  input  1  DEC-stage taken branch or jump
dec_halt  input  1  DEC-stage opcode is HALT
if_en  output  1  PC and IF/DEC latch enable
dec_en  output  1  DEC/EX latch enable
ex_en  output  1  EX/MEM latch enable
mem_en  output  1  MEM/WB latch enable
dec_flush  output  1  load NOP into IF/DEC latch
ex_flush  output  1  load NOP into DEC/EX latch
halted  output  1  pipeline halted (sticky)
mem_err  output  1  data-access timeout (sticky)
stall_cnt  output  CNT_W  stalled-cycle count

Behaviour:
- Reset (async, immediate): state=RUN; wait_cnt=0; drain_cnt=0; stall_cnt=0; halted=0; mem_err=0. Enable/flush outputs follow the combinational rules below, so in RUN with ihit=1 and no hazard all enables=1 and flushes=0.
- State register: RUN, DRAIN, HALTED. wait_cnt: 8-bit MEM-wait counter. drain_cnt: 2-bit.
- dreq = mem_dREN | mem_dWEN. dstall = dreq & ~dhit.
- lu_haz = ex_load & ex_dest!=0 & (ex_dest==dec_rs | (dec_uses_rt & ex_dest==dec_rt)).
- Per-cycle priority, highest first, all outputs combinational:
  1. HALTED: all enables=0, flushes=0.
  2. dstall: all enables=0 (full freeze), flushes=0.
  3. lu_haz: if_en=0, dec_en=0, ex_flush=1, ex_en=mem_en=1.
  4. dec_redirect & ~ihit: if_en=0, dec_en=0, ex_flush=1, downstream advances. The branch is held in DEC so the PC redirect is not lost.
  5. ~ihit: if_en=0, dec_flush=1, dec_en/ex_en/mem_en=1.
  6. dec_redirect: all enables=1, dec_flush=1 (squash delay-slot fetch).
  7. Otherwise: all enables=1, flushes=0.
- In DRAIN, if_en is forced 0 and dec_flush=1 after the rules above. The IF/DEC latch only receives NOPs. Rule 3 cannot fire; rules 4-6 are ignored.
- wait_cnt: increments on each dstall cycle; clears on any cycle without dstall. When wait_cnt==DWAIT_MAX with dstall: set mem_err, go HALTED next edge.
- RUN->DRAIN: dec_halt & dec_en & ~dstall. drain_cnt loads 3 on that edge.
- DRAIN: drain_cnt decrements on each edge with mem_en=1. When drain_cnt==1 and mem_en=1, go HALTED and set halted. The HALT then sits in WB; EX/MEM/WB have retired.
- HALTED is terminal until RST. halted and mem_err are sticky.
- stall_cnt increments on each cycle where if_en=0 and state!=HALTED. It saturates at all-ones and does not wrap.
- RST asserted mid-DWAIT or mid-DRAIN aborts immediately to reset values. No pending state survives.

Test Plan:
- Load-use: LW $2 in EX, DEC=ADD $3,$2,$4, ihit=dhit=1 -> exactly 1 cycle with if_en=0, dec_en=0, ex_flush=1. Next cycle all enables 1; stall_cnt=1. Same with ex_dest=0 -> no stall.
- Data wait: SW in MEM, dhit low 4 cycles -> all enables 0 for 4 cycles, advance on 5th; stall_cnt=4. Hold dhit low 256 cycles with DWAIT_MAX=255 -> mem_err=1, halted=0, all enables 0 thereafter.
- Branch with icache miss: dec_redirect=1, ihit=0 for 2 cycles -> if_en=dec_en=0, ex_flush=1 for 2 cycles. Then dec_flush=1, all enables 1 for 1 cycle.
- Priority: lu_haz and dstall together -> full freeze, ex_flush=0. After dhit, lu_haz bubble is issued once.
- Halt drain: HALT enters DEC, dstall injected 2 cycles during DRAIN -> halted asserts 3 mem_en cycles after the RUN->DRAIN edge (5 cycles total). if_en=0 throughout; halted stays 1.
- Reset mid-DRAIN: RST pulse asynchronously -> state RUN, halted=0, stall_cnt=0 before the next CLK edge.
